// File: rtl/gem_cluster_csc_window_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gem_cluster_csc_window_seq                                               |
// | Serial GEM cluster -> CSC wiregroup / key-halfstrip window translator.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gem_cluster_csc_window_seq #(
  parameter int NCLST        = 8,
  parameter int STRIPBITS    = 8,
  parameter int WIREBITS     = 7,
  parameter int MAXWIRE      = 47,
  parameter int NPADS        = 192,
  parameter int ME1A_ROLL    = 7,
  parameter int MINKEYHSME1B = 0,
  parameter int MAXKEYHSME1B = 127,
  parameter int MINKEYHSME1A = 128,
  parameter int MAXKEYHSME1A = 223,
  parameter int INVALID_HS   = 224
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           evenchamber,
  input  logic                           me11_mode,
  input  logic [4:0]                     gem_clct_deltahs,
  input  logic [2:0]                     gem_alct_deltawire,
  input  logic                           start,
  input  logic [NCLST-1:0]               cluster_vpf,
  input  logic [3*NCLST-1:0]             cluster_roll,
  input  logic [8*NCLST-1:0]             cluster_pad,
  input  logic [3*NCLST-1:0]             cluster_size,
  input  logic                           lut_we,
  input  logic [2:0]                     lut_sel,
  input  logic [7:0]                     lut_addr,
  input  logic [7:0]                     lut_wdata,
  output logic                           busy,
  output logic                           done,
  output logic                           lut_wr_drop,
  output logic [NCLST-1:0]               out_vpf,
  output logic [NCLST-1:0]               out_me1a,
  output logic [WIREBITS*NCLST-1:0]      out_wire_lo,
  output logic [WIREBITS*NCLST-1:0]      out_wire_hi,
  output logic [WIREBITS*NCLST-1:0]      out_wire_mi,
  output logic [STRIPBITS*NCLST-1:0]     out_hs_lo,
  output logic [STRIPBITS*NCLST-1:0]     out_hs_hi,
  output logic [STRIPBITS*NCLST-1:0]     out_hs_mi
);

  localparam int                   IDXW     = (NCLST > 1) ? $clog2(NCLST) : 1;
  localparam logic [IDXW-1:0]      LAST_IDX = IDXW'(NCLST - 1);
  localparam logic [8:0]           PAD_MAX  = 9'(NPADS - 1);
  localparam logic [2:0]           ROLL_A   = 3'(ME1A_ROLL);
  localparam logic [WIREBITS:0]    WG_MAX   = (WIREBITS+1)'(MAXWIRE);
  localparam logic [STRIPBITS:0]   HS_MIN_A = (STRIPBITS+1)'(MINKEYHSME1A);
  localparam logic [STRIPBITS:0]   HS_MAX_A = (STRIPBITS+1)'(MAXKEYHSME1A);
  localparam logic [STRIPBITS:0]   HS_MIN_B = (STRIPBITS+1)'(MINKEYHSME1B);
  localparam logic [STRIPBITS:0]   HS_MAX_B = (STRIPBITS+1)'(MAXKEYHSME1B);
  localparam logic [STRIPBITS-1:0] HS_INV   = STRIPBITS'(INVALID_HS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_e;

  state_e state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d, s1_idx_q, s1_idx_d, s2_idx_q, s2_idx_d;
  logic drain_q, drain_d, busy_q, busy_d, done_q, done_d, drop_q, drop_d;
  logic even_q, even_d, mode_q, mode_d;
  logic [4:0] dhs_q, dhs_d;
  logic [2:0] dwg_q, dwg_d;
  logic [NCLST-1:0] vpf_s_q, vpf_s_d;
  logic [3*NCLST-1:0] roll_s_q, roll_s_d, size_s_q, size_s_d;
  logic [8*NCLST-1:0] pad_s_q, pad_s_d;
  logic s1_v_q, s1_v_d, s1_vpf_q, s1_vpf_d, s1_me1a_q, s1_me1a_d;
  logic [9:0] s1_hsa_lo_q, s1_hsa_lo_d, s1_hsa_hi_q, s1_hsa_hi_d;
  logic [2:0] s1_roll_q, s1_roll_d;
  logic s2_v_q, s2_v_d, s2_vpf_q, s2_vpf_d, s2_me1a_q, s2_me1a_d;
  logic [STRIPBITS-1:0] s2_hs_a_q, s2_hs_a_d, s2_hs_b_q, s2_hs_b_d;
  logic [WIREBITS-1:0] s2_wg_a_q, s2_wg_a_d, s2_wg_b_q, s2_wg_b_d;
  logic [NCLST-1:0] out_vpf_q, out_vpf_d, out_me1a_q, out_me1a_d;
  logic [WIREBITS*NCLST-1:0] wlo_q, wlo_d, whi_q, whi_d, wmi_q, wmi_d;
  logic [STRIPBITS*NCLST-1:0] hlo_q, hlo_d, hhi_q, hhi_d, hmi_q, hmi_d;

  // HS tables addressed {~me1a, even, pad}; WG tables addressed {even, hi, roll}
  logic [STRIPBITS-1:0] hs_ram [0:1023];
  logic [WIREBITS-1:0]  wg_ram [0:31];

  logic       idle, cur_me1a;
  logic [2:0] cur_roll, cur_size;
  logic [7:0] cur_pad, pad_hi;
  logic [8:0] pad_sum;
  logic [STRIPBITS-1:0] hs_lo_v, hs_hi_v;
  logic [STRIPBITS:0]   hs_dx, hs_min, hs_max, hs_sum, hs_wlo, hs_whi, hs_mid;
  logic [WIREBITS-1:0]  wg_lo_v, wg_hi_v;
  logic [WIREBITS:0]    wg_dx, wg_sum, wg_wlo, wg_whi, wg_mid;

  assign idle = (state_q == S_IDLE);

  always_ff @(posedge clock) begin
    if (lut_we && idle && !lut_sel[2]) hs_ram[{lut_sel[1:0], lut_addr}] <= lut_wdata[STRIPBITS-1:0];
    if (lut_we && idle && lut_sel[2]) wg_ram[{lut_sel[1:0], lut_addr[2:0]}] <= lut_wdata[WIREBITS-1:0];
  end

  always_comb begin
    state_d = state_q;  idx_d = idx_q;  drain_d = drain_q;  busy_d = busy_q;
    done_d  = 1'b0;     drop_d = drop_q | (lut_we & ~idle);
    even_d = even_q;  mode_d = mode_q;  dhs_d = dhs_q;  dwg_d = dwg_q;
    vpf_s_d = vpf_s_q;  roll_s_d = roll_s_q;  pad_s_d = pad_s_q;  size_s_d = size_s_q;
    s1_v_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        even_d = evenchamber;  mode_d = me11_mode;
        dhs_d = gem_clct_deltahs;  dwg_d = gem_alct_deltawire;
        vpf_s_d = cluster_vpf;  roll_s_d = cluster_roll;
        pad_s_d = cluster_pad;  size_s_d = cluster_size;
        idx_d = '0;  state_d = S_ISSUE;  busy_d = 1'b1;
      end
      S_ISSUE: begin
        s1_v_d = 1'b1;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;  state_d = S_DRAIN;  drain_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (drain_q) begin
          state_d = S_IDLE;  busy_d = 1'b0;  done_d = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stage 1: address generation with pad_hi saturated at the last pad
    cur_roll = roll_s_q[idx_q*3 +: 3];
    cur_size = size_s_q[idx_q*3 +: 3];
    cur_pad  = pad_s_q[idx_q*8 +: 8];
    cur_me1a = mode_q & (cur_roll == ROLL_A);
    pad_sum  = {1'b0, cur_pad} + {6'b0, cur_size};
    pad_hi   = (pad_sum > PAD_MAX) ? PAD_MAX[7:0] : pad_sum[7:0];
    s1_vpf_d    = vpf_s_q[idx_q];
    s1_me1a_d   = cur_me1a;
    s1_idx_d    = idx_q;
    s1_roll_d   = cur_roll;
    s1_hsa_lo_d = {~cur_me1a, even_q, cur_pad};
    s1_hsa_hi_d = {~cur_me1a, even_q, pad_hi};

    // Stage 2: RAM read
    s2_v_d = s1_v_q;  s2_vpf_d = s1_vpf_q;  s2_me1a_d = s1_me1a_q;  s2_idx_d = s1_idx_q;
    s2_hs_a_d = hs_ram[s1_hsa_lo_q];
    s2_hs_b_d = hs_ram[s1_hsa_hi_q];
    s2_wg_a_d = wg_ram[{even_q, 1'b0, s1_roll_q}];
    s2_wg_b_d = wg_ram[{even_q, 1'b1, s1_roll_q}];

    // Stage 3: order, widen, clamp, midpoint of the clamped window
    hs_lo_v = (s2_hs_a_q <= s2_hs_b_q) ? s2_hs_a_q : s2_hs_b_q;
    hs_hi_v = (s2_hs_a_q <= s2_hs_b_q) ? s2_hs_b_q : s2_hs_a_q;
    hs_dx   = (STRIPBITS+1)'(dhs_q);
    hs_min  = s2_me1a_q ? HS_MIN_A : HS_MIN_B;
    hs_max  = s2_me1a_q ? HS_MAX_A : HS_MAX_B;
    hs_wlo  = ({1'b0, hs_lo_v} >= hs_min + hs_dx) ? {1'b0, hs_lo_v} - hs_dx : hs_min;
    hs_sum  = {1'b0, hs_hi_v} + hs_dx;
    hs_whi  = (hs_sum > hs_max) ? hs_max : hs_sum;
    hs_mid  = (hs_wlo + hs_whi + (STRIPBITS+1)'(1)) >> 1;
    wg_lo_v = (s2_wg_a_q <= s2_wg_b_q) ? s2_wg_a_q : s2_wg_b_q;
    wg_hi_v = (s2_wg_a_q <= s2_wg_b_q) ? s2_wg_b_q : s2_wg_a_q;
    wg_dx   = (WIREBITS+1)'(dwg_q);
    wg_wlo  = ({1'b0, wg_lo_v} > wg_dx) ? {1'b0, wg_lo_v} - wg_dx : '0;
    wg_sum  = {1'b0, wg_hi_v} + wg_dx;
    wg_whi  = (wg_sum > WG_MAX) ? WG_MAX : wg_sum;
    wg_mid  = (wg_wlo + wg_whi + (WIREBITS+1)'(1)) >> 1;

    out_vpf_d = out_vpf_q;  out_me1a_d = out_me1a_q;
    wlo_d = wlo_q;  whi_d = whi_q;  wmi_d = wmi_q;
    hlo_d = hlo_q;  hhi_d = hhi_q;  hmi_d = hmi_q;
    if (s2_v_q) begin
      out_vpf_d[s2_idx_q]  = s2_vpf_q;
      out_me1a_d[s2_idx_q] = s2_vpf_q & s2_me1a_q;
      wlo_d[s2_idx_q*WIREBITS +: WIREBITS]   = s2_vpf_q ? wg_wlo[WIREBITS-1:0] : '0;
      whi_d[s2_idx_q*WIREBITS +: WIREBITS]   = s2_vpf_q ? wg_whi[WIREBITS-1:0] : '0;
      wmi_d[s2_idx_q*WIREBITS +: WIREBITS]   = s2_vpf_q ? wg_mid[WIREBITS-1:0] : '0;
      hlo_d[s2_idx_q*STRIPBITS +: STRIPBITS] = s2_vpf_q ? hs_wlo[STRIPBITS-1:0] : HS_INV;
      hhi_d[s2_idx_q*STRIPBITS +: STRIPBITS] = s2_vpf_q ? hs_whi[STRIPBITS-1:0] : HS_INV;
      hmi_d[s2_idx_q*STRIPBITS +: STRIPBITS] = s2_vpf_q ? hs_mid[STRIPBITS-1:0] : HS_INV;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;  idx_q <= '0;  drain_q <= 1'b0;
      busy_q <= 1'b0;  done_q <= 1'b0;  drop_q <= 1'b0;
      even_q <= 1'b0;  mode_q <= 1'b0;  dhs_q <= '0;  dwg_q <= '0;
      vpf_s_q <= '0;  roll_s_q <= '0;  pad_s_q <= '0;  size_s_q <= '0;
      s1_v_q <= 1'b0;  s1_vpf_q <= 1'b0;  s1_me1a_q <= 1'b0;  s1_idx_q <= '0;
      s1_roll_q <= '0;  s1_hsa_lo_q <= '0;  s1_hsa_hi_q <= '0;
      s2_v_q <= 1'b0;  s2_vpf_q <= 1'b0;  s2_me1a_q <= 1'b0;  s2_idx_q <= '0;
      s2_hs_a_q <= '0;  s2_hs_b_q <= '0;  s2_wg_a_q <= '0;  s2_wg_b_q <= '0;
      out_vpf_q <= '0;  out_me1a_q <= '0;
      wlo_q <= '0;  whi_q <= '0;  wmi_q <= '0;
      hlo_q <= {NCLST{HS_INV}};  hhi_q <= {NCLST{HS_INV}};  hmi_q <= {NCLST{HS_INV}};
    end else begin
      state_q <= state_d;  idx_q <= idx_d;  drain_q <= drain_d;
      busy_q <= busy_d;  done_q <= done_d;  drop_q <= drop_d;
      even_q <= even_d;  mode_q <= mode_d;  dhs_q <= dhs_d;  dwg_q <= dwg_d;
      vpf_s_q <= vpf_s_d;  roll_s_q <= roll_s_d;  pad_s_q <= pad_s_d;  size_s_q <= size_s_d;
      s1_v_q <= s1_v_d;  s1_vpf_q <= s1_vpf_d;  s1_me1a_q <= s1_me1a_d;  s1_idx_q <= s1_idx_d;
      s1_roll_q <= s1_roll_d;  s1_hsa_lo_q <= s1_hsa_lo_d;  s1_hsa_hi_q <= s1_hsa_hi_d;
      s2_v_q <= s2_v_d;  s2_vpf_q <= s2_vpf_d;  s2_me1a_q <= s2_me1a_d;  s2_idx_q <= s2_idx_d;
      s2_hs_a_q <= s2_hs_a_d;  s2_hs_b_q <= s2_hs_b_d;  s2_wg_a_q <= s2_wg_a_d;  s2_wg_b_q <= s2_wg_b_d;
      out_vpf_q <= out_vpf_d;  out_me1a_q <= out_me1a_d;
      wlo_q <= wlo_d;  whi_q <= whi_d;  wmi_q <= wmi_d;
      hlo_q <= hlo_d;  hhi_q <= hhi_d;  hmi_q <= hmi_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign lut_wr_drop = drop_q;
  assign out_vpf     = out_vpf_q;
  assign out_me1a    = out_me1a_q;
  assign out_wire_lo = wlo_q;
  assign out_wire_hi = whi_q;
  assign out_wire_mi = wmi_q;
  assign out_hs_lo   = hlo_q;
  assign out_hs_hi   = hhi_q;
  assign out_hs_mi   = hmi_q;

endmodule
`default_nettype wire

// File: tb/tb_gem_cluster_csc_window_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gem_cluster_csc_window_seq                                            |
// | Directed and random runs checked against an arithmetic window model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_gem_cluster_csc_window_seq;
  localparam int N = 8;

  logic clock = 1'b0;
  logic reset_n;
  logic evenchamber, me11_mode, start, lut_we;
  logic [4:0] gem_clct_deltahs;
  logic [2:0] gem_alct_deltawire, lut_sel;
  logic [N-1:0] cluster_vpf;
  logic [3*N-1:0] cluster_roll, cluster_size;
  logic [8*N-1:0] cluster_pad;
  logic [7:0] lut_addr, lut_wdata;
  logic busy, done, lut_wr_drop;
  logic [N-1:0] out_vpf, out_me1a;
  logic [7*N-1:0] out_wire_lo, out_wire_hi, out_wire_mi;
  logic [8*N-1:0] out_hs_lo, out_hs_hi, out_hs_mi;

  gem_cluster_csc_window_seq #(.NCLST(N)) dut (
    .clock(clock), .reset_n(reset_n), .evenchamber(evenchamber), .me11_mode(me11_mode),
    .gem_clct_deltahs(gem_clct_deltahs), .gem_alct_deltawire(gem_alct_deltawire),
    .start(start), .cluster_vpf(cluster_vpf), .cluster_roll(cluster_roll),
    .cluster_pad(cluster_pad), .cluster_size(cluster_size), .lut_we(lut_we),
    .lut_sel(lut_sel), .lut_addr(lut_addr), .lut_wdata(lut_wdata), .busy(busy),
    .done(done), .lut_wr_drop(lut_wr_drop), .out_vpf(out_vpf), .out_me1a(out_me1a),
    .out_wire_lo(out_wire_lo), .out_wire_hi(out_wire_hi), .out_wire_mi(out_wire_mi),
    .out_hs_lo(out_hs_lo), .out_hs_hi(out_hs_hi), .out_hs_mi(out_hs_mi)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  // Reference tables indexed by lut_sel (0-3 HS, 4-7 WG as 0-3) and address
  int hs_m [4][256];
  int wg_m [4][8];
  int c_vpf [N], c_roll [N], c_pad [N], c_size [N];
  int even_v, mode_v, dhs_v, dwg_v;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic lut_write(input int sel, input int addr, input int data);
    lut_sel = 3'(sel);  lut_addr = 8'(addr);  lut_wdata = 8'(data);  lut_we = 1'b1;
    tick();
    lut_we = 1'b0;
    if (sel < 4) hs_m[sel][addr] = data;
    else         wg_m[sel-4][addr % 8] = data % 128;
  endtask

  task automatic drive_inputs();
    evenchamber = 1'(even_v);  me11_mode = 1'(mode_v);
    gem_clct_deltahs = 5'(dhs_v);  gem_alct_deltawire = 3'(dwg_v);
    for (int i = 0; i < N; i++) begin
      cluster_vpf[i]         = 1'(c_vpf[i]);
      cluster_roll[i*3 +: 3] = 3'(c_roll[i]);
      cluster_pad[i*8 +: 8]  = 8'(c_pad[i]);
      cluster_size[i*3 +: 3] = 3'(c_size[i]);
    end
  endtask

  task automatic randomize_clusters();
    for (int i = 0; i < N; i++) begin
      c_vpf[i]  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      c_roll[i] = $urandom_range(0, 7);
      c_pad[i]  = $urandom_range(0, 191);
      c_size[i] = $urandom_range(0, 7);
    end
  endtask

  function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
  function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

  // Expected per-cluster results: {vpf, me1a, wlo, whi, wmi, hlo, hhi, hmi}
  task automatic model(input int i, output int e [8]);
    int me1a, tbl, plo, phi, lo, hi, mn, mx, hl, hh, wl, wh;
    if (c_vpf[i] == 0) begin
      e = '{0, 0, 0, 0, 0, 224, 224, 224};
      return;
    end
    me1a = (mode_v != 0 && c_roll[i] == 7) ? 1 : 0;
    tbl  = me1a ? (even_v ? 1 : 0) : (even_v ? 3 : 2);
    plo  = c_pad[i];
    phi  = imin(c_pad[i] + c_size[i], 191);
    lo   = imin(hs_m[tbl][plo], hs_m[tbl][phi]);
    hi   = imax(hs_m[tbl][plo], hs_m[tbl][phi]);
    mn   = me1a ? 128 : 0;
    mx   = me1a ? 223 : 127;
    hl   = imax(lo - dhs_v, mn);
    hh   = imin(hi + dhs_v, mx);
    lo   = imin(wg_m[even_v ? 2 : 0][c_roll[i]], wg_m[even_v ? 3 : 1][c_roll[i]]);
    hi   = imax(wg_m[even_v ? 2 : 0][c_roll[i]], wg_m[even_v ? 3 : 1][c_roll[i]]);
    wl   = imax(lo - dwg_v, 0);
    wh   = imin(hi + dwg_v, 47);
    e = '{1, me1a, wl, wh, (wl + wh + 1) / 2, hl, hh, (hl + hh + 1) / 2};
  endtask

  task automatic compare_outputs();
    int e [8];
    for (int i = 0; i < N; i++) begin
      model(i, e);
      check_val($sformatf("vpf[%0d]", i),     64'(out_vpf[i]),              64'(e[0]));
      check_val($sformatf("me1a[%0d]", i),    64'(out_me1a[i]),             64'(e[1]));
      check_val($sformatf("wire_lo[%0d]", i), 64'(out_wire_lo[i*7 +: 7]),   64'(e[2]));
      check_val($sformatf("wire_hi[%0d]", i), 64'(out_wire_hi[i*7 +: 7]),   64'(e[3]));
      check_val($sformatf("wire_mi[%0d]", i), 64'(out_wire_mi[i*7 +: 7]),   64'(e[4]));
      check_val($sformatf("hs_lo[%0d]", i),   64'(out_hs_lo[i*8 +: 8]),     64'(e[5]));
      check_val($sformatf("hs_hi[%0d]", i),   64'(out_hs_hi[i*8 +: 8]),     64'(e[6]));
      check_val($sformatf("hs_mi[%0d]", i),   64'(out_hs_mi[i*8 +: 8]),     64'(e[7]));
    end
  endtask

  // One run; restart_at / we_at give edges (start edge = 0) for a stray start or LUT write
  task automatic run(input int restart_at, input int we_at);
    int got_done = -1;
    int busy_low = 0;
    drive_inputs();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("busy_after_start", 64'(busy), 64'd1);
    for (int e = 1; e <= 3 * N + 20 && got_done < 0; e++) begin
      start = (e == restart_at);
      if (e == we_at) begin
        lut_sel = 3'd3;  lut_addr = 8'd10;  lut_wdata = 8'd0;  lut_we = 1'b1;
      end
      tick();
      start = 1'b0;  lut_we = 1'b0;
      if (done) got_done = e;
      else if (!busy) busy_low++;
    end
    check_val("done_edge", 64'(got_done), 64'(N + 2));
    check_val("busy_low_in_run", 64'(busy_low), 64'd0);
    check_val("busy_at_done", 64'(busy), 64'd0);
    tick();
    check_val("done_one_cycle", 64'(done), 64'd0);
    compare_outputs();
  endtask

  task automatic set_t1();
    randomize_clusters();
    even_v = 1;  mode_v = 1;  dhs_v = 4;  dwg_v = 2;
    c_vpf[0] = 1;  c_roll[0] = 3;  c_pad[0] = 10;  c_size[0] = 2;
  endtask

  logic [63:0] inv_vec;
  int done_seen;

  initial begin
    reset_n = 1'b0;  start = 1'b0;  lut_we = 1'b0;  lut_sel = '0;  lut_addr = '0;  lut_wdata = '0;
    even_v = 0;  mode_v = 0;  dhs_v = 0;  dwg_v = 0;
    for (int i = 0; i < N; i++) begin c_vpf[i] = 0; c_roll[i] = 0; c_pad[i] = 0; c_size[i] = 0; end
    drive_inputs();
    inv_vec = '0;
    for (int i = 0; i < N; i++) inv_vec[i*8 +: 8] = 8'd224;
    tick();
    tick();
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_drop", 64'(lut_wr_drop), 64'd0);
    check_val("rst_vpf", 64'(out_vpf), 64'd0);
    check_val("rst_wire_lo", 64'(out_wire_lo), 64'd0);
    check_val("rst_hs_lo", out_hs_lo, inv_vec);
    check_val("rst_hs_mi", out_hs_mi, inv_vec);
    reset_n = 1'b1;
    tick();

    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 256; a++) lut_write(s, a, $urandom_range(0, 255));
    for (int s = 4; s < 8; s++)
      for (int a = 0; a < 8; a++) lut_write(s, a, $urandom_range(0, 60));

    // Even chamber ME1b HS window and WG window with swapped LUT outputs
    lut_write(3, 10, 100);  lut_write(3, 12, 94);
    lut_write(6, 3, 20);    lut_write(7, 3, 15);
    set_t1();
    run(-1, -1);
    check_val("t1_hs_lo", 64'(out_hs_lo[7:0]), 64'd90);
    check_val("t1_hs_hi", 64'(out_hs_hi[7:0]), 64'd104);
    check_val("t1_hs_mi", 64'(out_hs_mi[7:0]), 64'd97);
    check_val("t1_me1a", 64'(out_me1a[0]), 64'd0);
    check_val("t1_wire_lo", 64'(out_wire_lo[6:0]), 64'd13);
    check_val("t1_wire_hi", 64'(out_wire_hi[6:0]), 64'd22);
    check_val("t1_wire_mi", 64'(out_wire_mi[6:0]), 64'd18);

    // Odd chamber ME1a with upper clamp, then the same cluster in single-region mode
    lut_write(0, 100, 220);  lut_write(0, 101, 222);
    randomize_clusters();
    even_v = 0;  mode_v = 1;  dhs_v = 4;  dwg_v = 1;
    c_vpf[0] = 1;  c_roll[0] = 7;  c_pad[0] = 100;  c_size[0] = 1;
    run(-1, -1);
    check_val("t2_hs_lo", 64'(out_hs_lo[7:0]), 64'd216);
    check_val("t2_hs_hi", 64'(out_hs_hi[7:0]), 64'd223);
    check_val("t2_hs_mi", 64'(out_hs_mi[7:0]), 64'd220);
    check_val("t2_me1a", 64'(out_me1a[0]), 64'd1);
    mode_v = 0;
    run(-1, -1);
    check_val("t2b_me1a", 64'(out_me1a[0]), 64'd0);

    // WG clamps, pad_hi saturation, invalid cluster
    lut_write(4, 2, 1);  lut_write(5, 2, 46);
    lut_write(2, 190, 10);  lut_write(2, 191, 50);  lut_write(2, 197, 200);
    randomize_clusters();
    even_v = 0;  mode_v = 0;  dhs_v = 0;  dwg_v = 3;
    c_vpf[0] = 1;  c_roll[0] = 2;  c_pad[0] = 190;  c_size[0] = 7;
    c_vpf[1] = 0;
    run(-1, -1);
    check_val("t3_wire_lo", 64'(out_wire_lo[6:0]), 64'd0);
    check_val("t3_wire_hi", 64'(out_wire_hi[6:0]), 64'd47);
    check_val("t3_hs_lo", 64'(out_hs_lo[7:0]), 64'd10);
    check_val("t3_hs_hi", 64'(out_hs_hi[7:0]), 64'd50);
    check_val("t3_inv_hs", 64'(out_hs_lo[15:8]), 64'd224);
    check_val("t3_inv_wire", 64'(out_wire_hi[13:7]), 64'd0);

    // Stray start at edge 4 and LUT write at edge 5 while busy
    set_t1();
    run(4, 5);
    check_val("drop_sticky", 64'(lut_wr_drop), 64'd1);
    set_t1();
    run(-1, -1);
    check_val("drop_table_kept", 64'(out_hs_lo[7:0]), 64'd90);
    check_val("drop_still_set", 64'(lut_wr_drop), 64'd1);

    // Reset in the middle of a run
    randomize_clusters();
    drive_inputs();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check_val("mid_rst_busy", 64'(busy), 64'd0);
    check_val("mid_rst_done", 64'(done), 64'd0);
    check_val("mid_rst_drop", 64'(lut_wr_drop), 64'd0);
    check_val("mid_rst_vpf", 64'(out_vpf), 64'd0);
    check_val("mid_rst_hs_hi", out_hs_hi, inv_vec);
    check_val("mid_rst_wire_mi", 64'(out_wire_mi), 64'd0);
    tick();
    reset_n = 1'b1;
    done_seen = 0;
    for (int e = 0; e < 16; e++) begin
      tick();
      if (done) done_seen++;
    end
    check_val("mid_rst_no_done", 64'(done_seen), 64'd0);

    // Random runs with occasional LUT updates in between
    for (int r = 0; r < 24; r++) begin
      if (r % 3 == 0) begin
        lut_write($urandom_range(0, 3), $urandom_range(0, 191), $urandom_range(0, 255));
        lut_write($urandom_range(4, 7), $urandom_range(0, 7), $urandom_range(0, 63));
      end
      randomize_clusters();
      even_v = $urandom_range(0, 1);
      mode_v = $urandom_range(0, 1);
      dhs_v  = $urandom_range(0, 31);
      dwg_v  = $urandom_range(0, 7);
      run(-1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gem_cluster_csc_window_seq.md
Name: gem_cluster_csc_window_seq

Overview:
- Sequential, parametrised successor to the single-cluster GEM→CSC coordinate translator.
- Accepts a snapshot of NCLST GEM clusters per BX and maps each one serially through loadable pad→halfstrip and roll→wiregroup LUT RAMs (one cluster per cycle, dual read for lo/hi pad).
- Produces clamped CSC wiregroup and key-halfstrip matching windows per cluster for the GEM-CSC matcher.
- Adds runtime LUT loading, ME1/1 vs single-region mode, pad_hi saturation and a start/busy/done handshake.

Parameters:
- NCLST, 8, clusters per snapshot (≥1).
- STRIPBITS, 8, halfstrip width.
- WIREBITS, 7, wiregroup width.
- MAXWIRE, 47, highest wiregroup.
- NPADS, 192, pads per roll.
- ME1A_ROLL, 7, roll mapped to ME1a.
- MINKEYHSME1B / MAXKEYHSME1B, 0 / 127, ME1b key-HS range.
- MINKEYHSME1A / MAXKEYHSME1A, 128 / 223, ME1a key-HS range.
- INVALID_HS, 224, marker for an unmapped halfstrip.

Ports:
- clock  in  1  logic clock.
- reset_n  in  1  asynchronous, active-low reset.
- evenchamber  in  1  selects even/odd LUTs; sampled at start.
- me11_mode  in  1  1 = split ME1a/ME1b; 0 = all rolls use ME1b tables/range; sampled at start.
- gem_clct_deltahs  in  5  HS window half-width; sampled at start.
- gem_alct_deltawire  in  3  WG window half-width; sampled at start.
- start  in  1  one-cycle strobe that captures the cluster snapshot.
- cluster_vpf  in  NCLST  per-cluster valid.
- cluster_roll  in  3*NCLST  roll 0-7.
- cluster_pad  in  8*NCLST  pad 0-191.
- cluster_size  in  3*NCLST  size, 0 = 1 pad.
- lut_we  in  1  LUT write strobe.
- lut_sel  in  3  table select: 0 hs_me1a_odd, 1 hs_me1a_even, 2 hs_me1b_odd, 3 hs_me1b_even, 4 wg_odd_lo, 5 wg_odd_hi, 6 wg_even_lo, 7 wg_even_hi.
- lut_addr  in  8  pad address; WG tables use bits [2:0].
- lut_wdata  in  8  data; WG tables use [WIREBITS-1:0].
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.
- lut_wr_drop  out  1  sticky: a write arrived while busy.
- out_vpf  out  NCLST  registered valid.
- out_me1a  out  NCLST  cluster mapped to ME1a.
- out_wire_lo / out_wire_hi / out_wire_mi  out  WIREBITS*NCLST  WG window.
- out_hs_lo / out_hs_hi / out_hs_mi  out  STRIPBITS*NCLST  key-HS window in the selected region.

Behaviour:
- Reset (async assert, sync release) values: FSM IDLE; busy=0, done=0, lut_wr_drop=0; out_vpf=0, out_me1a=0; all wire fields=0; all hs fields=INVALID_HS. LUT RAM contents are not reset.
- FSM states:
  - IDLE: start → capture the snapshot and the sampled controls; idx=0; go to ISSUE; busy=1.
  - ISSUE: each cycle present addresses for cluster idx to the RAMs, idx++; after idx=NCLST-1 go to DRAIN.
  - DRAIN: 2 cycles while the pipeline empties, then go to IDLE; done=1 for exactly one cycle, busy=0 in that same cycle.
- Pipeline per cluster:
  - Stage 1: address registered.
  - Stage 2: RAM data.
  - Stage 3: window arithmetic and output register written.
  - Results for cluster i are written at edge T0+i+3 (T0 = start edge).
  - done is asserted in the cycle after edge T0+NCLST+2, when all results are valid.
- Other outputs hold until they are overwritten during the next run.
- start while busy: ignored.
- LUT writes:
  - lut_we while IDLE: synchronous write at the next edge.
  - lut_we while busy: dropped and lut_wr_drop set (cleared only by reset).
- Arithmetic, per valid cluster:
  - pad_lo = pad; pad_hi = min(pad+size, NPADS-1), computed at 9 bits before saturation.
  - LUT outputs are swapped so that lo ≤ hi.
  - Wire window: wire_lo = (lo>delta) ? lo-delta : 0; wire_hi = min(hi+delta, MAXWIRE).
  - me1a = me11_mode && roll==ME1A_ROLL.
  - HS window uses the matching range [MIN,MAX] for the selected region: hs_lo = max(lo-delta, MIN); hs_hi = min(hi+delta, MAX). Compare at STRIPBITS+1 bits; no underflow or overflow.
  - Midpoint: mi = (lo+hi+1)>>1 at width+1, for both wire and HS.
- Invalid cluster (vpf=0): out_vpf=0, out_me1a=0, wire fields=0, hs fields=INVALID_HS; LUT data is ignored.
- Reset mid-run: returns immediately to reset values; no done pulse.

Test Plan:
- Even chamber, deltahs=4: load hs_me1b_even[10]=100 and [12]=94; cluster0 vpf=1 roll=3 pad=10 size=2 → hs_lo=90, hs_hi=104, hs_mi=97, out_me1a=0.
- Same run, deltawire=2: load wg_even_lo[3]=20 and wg_even_hi[3]=15 → wire_lo=13, wire_hi=22, wire_mi=18.
- Odd chamber, me11_mode=1: load hs_me1a_odd[100]=220 and [101]=222; cluster roll=7 pad=100 size=1, deltahs=4 → lo=216, hi=223 (clamped), mi=220, me1a=1. Rerun with me11_mode=0 → ME1b tables are used, me1a=0.
- Clamp and saturation:
  - WG lo=1, hi=46, deltawire=3 → wire_lo=0, wire_hi=47.
  - pad=190 size=7 → RAM read at pad 191 (bench checks via distinct contents).
  - vpf=0 → hs fields=224, wires=0.
- Handshake, NCLST=8, start at edge 0: busy high from edge 0; done high for exactly one cycle after edge 10. A second start at edge 4 is ignored. lut_we at edge 5 sets lut_wr_drop=1 and leaves the table unchanged.
- reset_n asserted at edge 5 of a run → busy=0 and outputs at reset values immediately; no done pulse; a new start after release completes normally.
